// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit, the decoder that drives
// md_op/start, and the stall logic that watches busy.
package md_pkg;

  // md_op encodings; 3'd7 is reserved and behaves like MD_NONE
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Default busy durations
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the four operations that occupy the unit for several cycles
  function automatic logic is_calc_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. The result is computed in the start
// cycle and parked in temp registers; HI/LO are only updated once the busy
// window has elapsed, so software-visible timing matches a multi-cycle unit.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      tmp_hi_r;
  logic [31:0]      tmp_lo_r;
  logic             hold_r;     // divide by zero: leave HI/LO alone at commit

  logic [63:0]      prod_s;
  logic [31:0]      next_hi_s;
  logic [31:0]      next_lo_s;
  logic             is_div_s;
  logic             div_zero_s;
  logic             accept_s;
  logic             mt_hi_s;
  logic             mt_lo_s;

  // Single-cycle arithmetic on the operands present in the start cycle
  always_comb begin
    prod_s    = 64'd0;
    next_hi_s = 32'd0;
    next_lo_s = 32'd0;
    case (md_op)
      MD_MULT: begin
        prod_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        next_hi_s = prod_s[63:32];
        next_lo_s = prod_s[31:0];
      end
      MD_MULTU: begin
        prod_s    = {32'd0, A} * {32'd0, B};
        next_hi_s = prod_s[63:32];
        next_lo_s = prod_s[31:0];
      end
      MD_DIV: begin
        // Division by zero is guarded so no X reaches the temp registers
        if (B != 32'd0) begin
          next_lo_s = $signed(A) / $signed(B);
          next_hi_s = $signed(A) % $signed(B);
        end else begin
          next_lo_s = 32'd0;
          next_hi_s = 32'd0;
        end
      end
      MD_DIVU: begin
        if (B != 32'd0) begin
          next_lo_s = A / B;
          next_hi_s = A % B;
        end else begin
          next_lo_s = 32'd0;
          next_hi_s = 32'd0;
        end
      end
      default: begin
        prod_s    = 64'd0;
        next_hi_s = 32'd0;
        next_lo_s = 32'd0;
      end
    endcase
  end

  // Decide which request, if any, is honoured this cycle
  always_comb begin
    is_div_s   = (md_op == MD_DIV) || (md_op == MD_DIVU);
    div_zero_s = is_div_s && (B == 32'd0);
    accept_s   = (state_r == ST_IDLE) && start && is_calc_op(md_op);
    mt_hi_s    = (state_r == ST_IDLE) && !start && (md_op == MD_MTHI);
    mt_lo_s    = (state_r == ST_IDLE) && !start && (md_op == MD_MTLO);
  end

  // Sequencer: IDLE/CALC, busy countdown, HI/LO commit and mthi/mtlo writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      tmp_hi_r <= 32'd0;
      tmp_lo_r <= 32'd0;
      hold_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tmp_hi_r <= next_hi_s;
            tmp_lo_r <= next_lo_s;
            hold_r   <= div_zero_s;
            cnt_r    <= is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_r   <= 1'b1;
            state_r  <= ST_CALC;
          end else if (mt_hi_s) begin
            hi_r <= A;
          end else if (mt_lo_s) begin
            lo_r <= A;
          end
        end
        ST_CALC: begin
          // Anything arriving on md_op/start here is ignored
          if (cnt_r == CNT_W'(1)) begin
            if (!hold_r) begin
              hi_r <= tmp_hi_r;
              lo_r <= tmp_lo_r;
            end
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with hand-computed expected values.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  md_op;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_mis = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .md_op (md_op),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a start pulse for one edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; md_op = MD_NONE;
  endtask

  // count cycles with busy high, bounded so a stuck busy cannot hang the run
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  // write HI or LO through mthi/mtlo while idle
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    md_op = op; A = a; start = 1'b0;
    step();
    md_op = MD_NONE;
  endtask

  int n;

  initial begin
    reset = 1'b1; A = 32'd0; B = 32'd0; md_op = MD_NONE; start = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // mult -1 * 2
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2 -> q=-3, r=-1
    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // divu 7 / 2
    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_cycles", n, 32'd10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    // divide by zero leaves preset HI/LO
    mt(MD_MTHI, 32'h1111_1111);
    mt(MD_MTLO, 32'h2222_2222);
    check("mthi_val", HI, 32'h1111_1111);
    check("mtlo_val", LO, 32'h2222_2222);
    issue(MD_DIV, 32'd123, 32'd0);
    wait_idle(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", HI, 32'h1111_1111);
    check("div0_lo", LO, 32'h2222_2222);

    // mtlo while idle: visible next cycle, no busy
    mt(MD_MTLO, 32'hDEAD_BEEF);
    check("mtlo_lo", LO, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // mthi during busy is ignored; mult 3*4 commits afterwards
    issue(MD_MULT, 32'd3, 32'd4);
    md_op = MD_MTHI; A = 32'hCAFE_F00D;
    step();
    md_op = MD_NONE;
    check("mthi_busy_hi", HI, 32'h1111_1111);
    check("mthi_busy_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("mthi_busy_cycles", n, 32'd4);
    check("mthi_busy_hi_after", HI, 32'd0);
    check("mthi_busy_lo_after", LO, 32'd12);

    // start while busy is ignored: 0x10000 * 0x10000 = 2^32
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
    issue(MD_DIV, 32'd100, 32'd7);
    wait_idle(n);
    check("sb_cycles", n, 32'd4);
    check("sb_hi", HI, 32'd1);
    check("sb_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) begin
        check("sb_no_second_busy", {31'd0, busy}, 32'd0);
      end
      step();
    end
    check("sb_hi_late", HI, 32'd1);

    // mult opcode without start, and start with mthi opcode: both no-ops
    md_op = MD_MULT; A = 32'd9; B = 32'd9;
    step();
    md_op = MD_MTHI; start = 1'b1; A = 32'h5555_5555;
    step();
    start = 1'b0; md_op = MD_NONE;
    check("noop_busy", {31'd0, busy}, 32'd0);
    check("noop_hi", HI, 32'd1);
    check("noop_lo", LO, 32'd0);

    // reset mid-calculation discards the result
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) step();
    check("rst_mid_busy_late", {31'd0, busy}, 32'd0);
    check("rst_mid_hi_late", HI, 32'd0);
    check("rst_mid_lo_late", LO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
